// File: rtl/timer_hex_driver.sv
// Extends the upstream BCD seconds count into an HH:MM:SS clock.
// Drives the six active-low seven-segment displays HEX5..HEX0 as HH MM SS.
module timer_hex_driver #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       myreset_n,
    input  logic [7:0] timerdisplay,
    input  logic       clear,
    output logic [7:0] minutes,
    output logic [7:0] hours,
    output logic       rollover,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    // Only ever applied to legal BCD values; the wrap limits are handled by the caller.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hr_q, hr_d;
    logic       roll_q, roll_d;
    logic [6:0] hex0_q, hex0_d;
    logic [6:0] hex1_q, hex1_d;
    logic [6:0] hex2_q, hex2_d;
    logic [6:0] hex3_q, hex3_d;
    logic [6:0] hex4_q, hex4_d;
    logic [6:0] hex5_q, hex5_d;

    logic min_tick;
    logic hour_tick;
    logic day_wrap;

    always_comb begin
        sec_d     = timerdisplay;
        min_d     = min_q;
        hr_d      = hr_q;
        roll_d    = 1'b0;

        // Only a genuine 59 -> 00 step of the seconds counter advances minutes.
        min_tick  = (sec_q == 8'h59) && (timerdisplay == 8'h00);
        hour_tick = min_tick && (min_q == 8'h59);
        day_wrap  = hour_tick && (hr_q == 8'h23);

        if (clear) begin
            min_d = 8'h00;
            hr_d  = 8'h00;
        end else if (min_tick) begin
            min_d = hour_tick ? 8'h00 : bcd_inc(min_q);
            if (hour_tick) begin
                hr_d = day_wrap ? 8'h00 : bcd_inc(hr_q);
            end
            roll_d = day_wrap;
        end
    end

    // Display registers sample the counter registers, so seconds and minutes
    // digits of a tick always change on the same edge.
    always_comb begin
        hex0_d = seg_decode(sec_q[3:0]);
        hex1_d = seg_decode(sec_q[7:4]);
        hex2_d = seg_decode(min_q[3:0]);
        hex3_d = seg_decode(min_q[7:4]);
        hex4_d = seg_decode(hr_q[3:0]);
        hex5_d = seg_decode(hr_q[7:4]);
        if (BLANK_LEADING && (hr_q[7:4] == 4'd0)) begin
            hex5_d = SEG_BLANK;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge myreset_n) begin
        if (!myreset_n) begin
            sec_q  <= 8'h00;
            min_q  <= 8'h00;
            hr_q   <= 8'h00;
            roll_q <= 1'b0;
            hex0_q <= SEG_BLANK;
            hex1_q <= SEG_BLANK;
            hex2_q <= SEG_BLANK;
            hex3_q <= SEG_BLANK;
            hex4_q <= SEG_BLANK;
            hex5_q <= SEG_BLANK;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
            roll_q <= roll_d;
            hex0_q <= hex0_d;
            hex1_q <= hex1_d;
            hex2_q <= hex2_d;
            hex3_q <= hex3_d;
            hex4_q <= hex4_d;
            hex5_q <= hex5_d;
        end
    end

    assign minutes  = min_q;
    assign hours    = hr_q;
    assign rollover = roll_q;
    assign HEX0     = hex0_q;
    assign HEX1     = hex1_q;
    assign HEX2     = hex2_q;
    assign HEX3     = hex3_q;
    assign HEX4     = hex4_q;
    assign HEX5     = hex5_q;

endmodule
